// File: rtl/fbuf_reader_if.sv
// Bus bundle for the frame reader.
// Carries the framebuffer read port and the downstream FIFO write port.
// The reader is the master on both halves.
interface fbuf_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 18
);
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  sof;
  logic                  eof;
  logic                  almostfull;

  modport master (
    output raddr, wr, wdata, sof, eof,
    input  rdata, almostfull
  );

  modport slave (
    input  raddr, wr, wdata, sof, eof,
    output rdata, almostfull
  );
endinterface

// File: rtl/fbuf_reader.sv
// Frame reader for the colour-detect framebuffer.
// A start pulse reads one whole frame in ascending address order.
// Reads issue only while the downstream FIFO is not almost full.
// A tag pipe follows each issued read through the BRAM latency, so every
// word reaches the FIFO exactly once, in order, with sof/eof markers.
module fbuf_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BRAM_DEPTH = 230400,
  parameter int RD_LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_flush,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_frame_done,
  fbuf_reader_if.master bus
);
  localparam int            AW        = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  clear;
  logic                  issue;
  logic                  last_addr;
  logic                  eof_written;
  logic [AW-1:0]         raddr_q;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_sof;
  logic [RD_LATENCY-1:0] pipe_eof;
  logic                  wr_q;
  logic                  sof_q;
  logic                  eof_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Reset and flush do the same thing.
  // In-flight reads are thrown away instead of being written.
  assign clear       = !i_rstn || i_flush;
  assign eof_written = wr_q && eof_q;

  // State register; reset and flush return the FSM to IDLE
  always_ff @(posedge i_clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // The eof write is the last word in the pipe, so DRAIN ends when it appears.
  // A start is not taken in the frame_done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start && !done_q) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (issue && last_addr) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (eof_written) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  // A read issues only in ACTIVE, and only while the FIFO has room.
  always_comb begin
    issue     = (state_q == ACTIVE) && !bus.almostfull;
    last_addr = (raddr_q == LAST_ADDR);
    o_busy    = (state_q != IDLE);
  end

  // Read address counts up and wraps to 0 after the last word.
  // BRAM_DEPTH may be any size, so the wrap is an explicit compare.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      raddr_q <= '0;
    end else if (issue) begin
      raddr_q <= last_addr ? '0 : raddr_q + AW'(1);
    end
  end

  // Tag pipe: carries valid/sof/eof alongside each read until its data is valid
  always_ff @(posedge i_clk) begin
    if (clear) begin
      pipe_valid <= '0;
      pipe_sof   <= '0;
      pipe_eof   <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_sof[0]   <= issue && (raddr_q == '0);
      pipe_eof[0]   <= issue && last_addr;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_sof[k]   <= pipe_sof[k-1];
        pipe_eof[k]   <= pipe_eof[k-1];
      end
    end
  end

  // Registered FIFO write and frame_done pulse.
  // wdata holds its last value between writes.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      wr_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      wr_q   <= pipe_valid[RD_LATENCY-1];
      sof_q  <= pipe_valid[RD_LATENCY-1] && pipe_sof[RD_LATENCY-1];
      eof_q  <= pipe_valid[RD_LATENCY-1] && pipe_eof[RD_LATENCY-1];
      done_q <= (state_q == DRAIN) && eof_written;
      if (pipe_valid[RD_LATENCY-1]) begin
        wdata_q <= bus.rdata;
      end
    end
  end

  assign bus.raddr    = raddr_q;
  assign bus.wr       = wr_q;
  assign bus.wdata    = wdata_q;
  assign bus.sof      = sof_q;
  assign bus.eof      = eof_q;
  assign o_frame_done = done_q;
endmodule
